// File: rtl/sqrt_vec_issue.sv
// sqrt_vec_issue: sequences the enabled BF16 elements of a vector, one at a
// time, through an external scalar sqrt unit and returns the assembled result.
// Optional feature: define SQRT_ISSUE_TIMEOUT_EN to add a per-element watchdog
// that substitutes a quiet NaN (16'h7FC0) and raises a sticky err_timeout.
module sqrt_vec_issue #(
  parameter int NUM_ELEM       = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic                  vec_valid_in,
  output logic                  vec_ready_in,
  input  logic [NUM_ELEM*16-1:0] vec_operand,
  input  logic [NUM_ELEM-1:0]   vec_mask,
  output logic                  vec_valid_out,
  input  logic                  vec_ready_out,
  output logic [NUM_ELEM*16-1:0] vec_result,
  output logic                  sq_valid_in,
  output logic [15:0]           sq_operand,
  input  logic                  sq_ready_in,
  input  logic                  sq_valid_out,
  input  logic [15:0]           sq_result,
  output logic                  sq_ready_out,
  output logic                  err_timeout
);

  localparam int IW = (NUM_ELEM > 1) ? $clog2(NUM_ELEM) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t                     state_q, state_d;
  logic [IW-1:0]              idx_q, idx_d;
  logic [NUM_ELEM-1:0][15:0]  op_q, op_d;
  logic [NUM_ELEM-1:0]        mask_q, mask_d;
  logic [NUM_ELEM-1:0][15:0]  res_q, res_d;
  logic [IW:0]                nxt;
  logic                       advance;

`ifdef SQRT_ISSUE_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  assign err_timeout = err_q;
`else
  // Watchdog limit has no use when the watchdog is compiled out.
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign err_timeout = 1'b0;
`endif

  // Returns {found, index} of the lowest set mask bit at or above 'from'.
  function automatic logic [IW:0] next_set(input logic [NUM_ELEM-1:0] m, input int from);
    logic [IW:0] r;
    r = '0;
    for (int i = NUM_ELEM - 1; i >= 0; i--)
      if (m[i] && i >= from) r = {1'b1, IW'(i)};
    return r;
  endfunction

  assign vec_result = res_q;

  // Next-state, datapath updates and handshake outputs.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    op_d          = op_q;
    mask_d        = mask_q;
    res_d         = res_q;
    nxt           = '0;
    advance       = 1'b0;
    vec_ready_in  = 1'b0;
    vec_valid_out = 1'b0;
    sq_valid_in   = 1'b0;
    sq_operand    = '0;
    sq_ready_out  = 1'b0;
`ifdef SQRT_ISSUE_TIMEOUT_EN
    cnt_d         = cnt_q;
    err_d         = err_q;
`endif
    case (state_q)
      IDLE: begin
        vec_ready_in = 1'b1;
        if (vec_valid_in) begin
          op_d    = vec_operand;
          mask_d  = vec_mask;
          res_d   = '0;
          nxt     = next_set(vec_mask, 0);
          idx_d   = nxt[IW-1:0];
          state_d = nxt[IW] ? ISSUE : DONE;
        end
      end
      ISSUE: begin
        sq_valid_in = 1'b1;
        sq_operand  = op_q[idx_q];
        if (sq_ready_in) begin
          state_d = WAIT;
`ifdef SQRT_ISSUE_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      WAIT: begin
        sq_ready_out = 1'b1;
        if (sq_valid_out) begin
          res_d[idx_q] = sq_result;
          advance      = 1'b1;
        end
`ifdef SQRT_ISSUE_TIMEOUT_EN
        else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          res_d[idx_q] = 16'h7FC0;
          err_d        = 1'b1;
          advance      = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
        // Always pass through ISSUE for the next element, never re-issue here.
        if (advance) begin
          nxt = next_set(mask_q, int'(idx_q) + 1);
          if (nxt[IW]) begin
            idx_d   = nxt[IW-1:0];
            state_d = ISSUE;
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        vec_valid_out = 1'b1;
        if (vec_ready_out) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset drops any in-flight element.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      idx_q   <= '0;
      op_q    <= '0;
      mask_q  <= '0;
      res_q   <= '0;
`ifdef SQRT_ISSUE_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      op_q    <= op_d;
      mask_q  <= mask_d;
      res_q   <= res_d;
`ifdef SQRT_ISSUE_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

endmodule
